uart_frame_collector: RTL and testbench
=======================================

# uart_frame_collector

Parametrised successor to the fixed N-byte UART reader. It assembles a configurable number of received UART bytes into one frame. It records a per-byte parity error mask and discards partial frames after an inter-byte timeout. It holds each completed frame in an output slot with a valid/ready handshake and flags an overrun. It sits between `uart_rx` (byte strobe side) and command/SPI logic (frame side).

## Interface
- `BYTE_NUM`, 4: bytes per frame, 1..16.
- `MSB_FIRST`, 1: 1 = first received byte lands in `frame_data_o[8*BYTE_NUM-1 -: 8]`; 0 = first byte lands in `[7:0]`.
- `TIMEOUT_CYCLES`, 114576: idle clock cycles allowed between bytes of one frame (about 2 char times at 9600 baud, 50 MHz); 0 disables the timeout.
- `clk_i`  in  1  single clock; all logic on rising edge.
- `rst_n_i`  in  1  reset, asynchronous, active-low.
- `rx_byte_valid_i`  in  1  one-cycle strobe: a byte has been received by `uart_rx`.
- `rx_byte_i`  in  8  received byte, sampled only when `rx_byte_valid_i`=1.
- `rx_parity_ok_i`  in  1  parity result for `rx_byte_i`, sampled with the strobe.
- `frame_ready_i`  in  1  consumer accepts the frame when `frame_valid_o` && `frame_ready_i`.
- `frame_valid_o`  out  1  output slot holds a frame; level, held until accepted.
- `frame_data_o`  out  8*BYTE_NUM  assembled frame; stable while `frame_valid_o`=1.
- `frame_err_o`  out  1  OR of `frame_err_mask_o`; qualified by `frame_valid_o`.
- `frame_err_mask_o`  out  BYTE_NUM  bit i = 1 if the i-th received byte (0 = first) failed parity.
- `busy_o`  out  1  high while a partial frame is being collected.
- `timeout_o`  out  1  one-cycle pulse: partial frame discarded by timeout.
- `overrun_o`  out  1  one-cycle pulse: completed frame dropped because the slot was full.

## Operation
- Collector FSM with two states:
  - IDLE: byte count 0, `busy_o`=0.
  - COLLECT: 1..BYTE_NUM-1 bytes held, `busy_o`=1.
- On each strobe:
  - Write the byte into the shift/assembly register at its position for the selected `MSB_FIRST` order.
  - Write `~rx_parity_ok_i` into the mask bit for its arrival index.
  - Increment the count (width `$clog2(BYTE_NUM+1)`).
- Frame completion is the strobe that delivers byte BYTE_NUM-1. BYTE_NUM=1 goes IDLE to complete on every strobe, with no COLLECT.
  - Slot empty, or slot being accepted this cycle: load data and mask into the slot; `frame_valid_o`=1 next cycle.
  - Slot full and not accepted this cycle: drop the new frame; pulse `overrun_o`. The slot contents are unchanged.
  - In both cases the collector returns to IDLE with the count cleared.
- Parity errors do not abort collection. A frame with errors is still delivered, with `frame_err_o`=1.
- Timeout:
  - The counter clears on every strobe and on entry to COLLECT, and increments each cycle in COLLECT.
  - When the count reaches TIMEOUT_CYCLES-1 with no strobe that cycle, the collector discards the partial frame, returns to IDLE and pulses `timeout_o`.
  - A strobe in the expiry cycle wins: the byte is accepted and the counter clears.
  - With TIMEOUT_CYCLES=0 the counter is not generated and a partial frame is held indefinitely.
- Output slot:
  - `frame_valid_o` clears the cycle after a handshake unless a new frame loads in the same cycle.
  - `frame_data_o`, `frame_err_o` and the mask never change while valid && !ready.

## Timing
- Reset values of the outputs:
  - `frame_valid_o`=0, `frame_err_o`=0, `busy_o`=0, `timeout_o`=0, `overrun_o`=0.
  - `frame_data_o`=0, `frame_err_mask_o`=0.
- Reset values of internal state: count=0, timeout counter=0, FSM in IDLE.
- Asserting reset mid-frame discards the partial frame and any pending slot immediately.
- Latency, final strobe at edge t:
  - `frame_valid_o`, data and mask are valid after edge t+1; registered, no combinational path from the inputs.
  - `overrun_o` and `timeout_o` are high for exactly one cycle, at the same t+1 alignment as the triggering event.
- `busy_o` rises the cycle after the first strobe and falls the cycle after completion or timeout.
- Strobes are assumed at most one per cycle. Back-to-back strobes on consecutive cycles must be accepted without loss.

## Test plan
- BYTE_NUM=4, MSB_FIRST=1: strobe 0x11, 0x22, 0x33, 0x44, all parity ok; ready=1 -> `frame_data_o`=0x11223344, `frame_err_o`=0, mask=4'b0000; `frame_valid_o` high for 1 cycle, one cycle after the 4th strobe.
- MSB_FIRST=0, same bytes, third byte with parity_ok=0 -> data=0x44332211, mask=4'b0100, `frame_err_o`=1.
- TIMEOUT_CYCLES=100: send 2 bytes, then nothing -> `timeout_o` pulses once, 100 cycles after the 2nd strobe; `busy_o`→0. Then 4 bytes AA BB CC DD -> data=0xAABBCCDD, no stale bytes.
- ready=0: complete frame A 0x01020304, then frame B 0x05060708 -> `overrun_o` pulses at B completion; the slot still reads 0x01020304. Raise ready -> A accepted, valid drops.
- ready asserted in the same cycle that frame C completes while A is pending -> A accepted, C loaded, `frame_valid_o` stays 1, no overrun.
- Reset asserted after byte 2 of a frame -> all outputs at reset values immediately. Then a full 4-byte frame is received correctly.

Source files
------------

// File: rtl/uart_frame_collector.sv
// Collects BYTE_NUM received UART bytes into one frame with a per-byte parity error mask.
// Completed frames go to a valid/ready output slot. A partial frame is dropped after an idle timeout.
module uart_frame_collector #(
    parameter int BYTE_NUM       = 4,
    parameter bit MSB_FIRST      = 1'b1,
    parameter int TIMEOUT_CYCLES = 114576
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  rx_byte_valid_i,
    input  logic [7:0]            rx_byte_i,
    input  logic                  rx_parity_ok_i,
    input  logic                  frame_ready_i,
    output logic                  frame_valid_o,
    output logic [8*BYTE_NUM-1:0] frame_data_o,
    output logic                  frame_err_o,
    output logic [BYTE_NUM-1:0]   frame_err_mask_o,
    output logic                  busy_o,
    output logic                  timeout_o,
    output logic                  overrun_o
);
    localparam int CW = $clog2(BYTE_NUM + 1);
    localparam int DW = 8 * BYTE_NUM;

    typedef enum logic {S_IDLE, S_COLLECT} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q;
    logic [DW-1:0]       asm_q, asm_d;
    logic [BYTE_NUM-1:0] amask_q, amask_d;
    logic                complete, expire, load;
    logic                timeout_q, overrun_q;

    // The arriving byte is merged combinationally so the final byte reaches the slot in the same edge
    always_comb begin
        asm_d   = asm_q;
        amask_d = amask_q;
        for (int i = 0; i < BYTE_NUM; i++) begin
            if (cnt_q == CW'(i)) begin
                if (MSB_FIRST) asm_d[8*(BYTE_NUM-1-i) +: 8] = rx_byte_i;
                else           asm_d[8*i +: 8]              = rx_byte_i;
                amask_d[i] = ~rx_parity_ok_i;
            end
        end
    end

    assign complete = rx_byte_valid_i && (cnt_q == CW'(BYTE_NUM - 1));
    assign load     = complete && (!frame_valid_o || frame_ready_i);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (rx_byte_valid_i && !complete) state_d = S_COLLECT;
            S_COLLECT: if (complete || expire)           state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    generate
        if (TIMEOUT_CYCLES > 0) begin : g_to
            localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
            logic [TW-1:0] to_cnt_q;

            always_ff @(posedge clk_i or negedge rst_n_i) begin
                if (!rst_n_i)
                    to_cnt_q <= '0;
                else if (state_q != S_COLLECT || rx_byte_valid_i || expire)
                    to_cnt_q <= '0;
                else
                    to_cnt_q <= to_cnt_q + 1'b1;
            end

            assign expire = (state_q == S_COLLECT) && !rx_byte_valid_i &&
                            (to_cnt_q == TW'(TIMEOUT_CYCLES - 1));
        end else begin : g_no_to
            assign expire = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q          <= S_IDLE;
            cnt_q            <= '0;
            asm_q            <= '0;
            amask_q          <= '0;
            frame_valid_o    <= 1'b0;
            frame_data_o     <= '0;
            frame_err_mask_o <= '0;
            timeout_q        <= 1'b0;
            overrun_q        <= 1'b0;
        end else begin
            state_q   <= state_d;
            timeout_q <= expire;
            overrun_q <= complete && !load;
            if (rx_byte_valid_i) begin
                asm_q   <= asm_d;
                amask_q <= amask_d;
                cnt_q   <= complete ? '0 : cnt_q + 1'b1;
            end else if (expire) begin
                cnt_q <= '0;
            end
            if (load) begin
                frame_valid_o    <= 1'b1;
                frame_data_o     <= asm_d;
                frame_err_mask_o <= amask_d;
            end else if (frame_valid_o && frame_ready_i) begin
                frame_valid_o <= 1'b0;
            end
        end
    end

    assign frame_err_o = |frame_err_mask_o;
    assign busy_o      = (state_q == S_COLLECT);
    assign timeout_o   = timeout_q;
    assign overrun_o   = overrun_q;
endmodule

// File: tb/tb_uart_frame_collector.sv
// Directed bench for uart_frame_collector: one MSB-first and one LSB-first instance share the stimulus.
module tb_uart_frame_collector;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_byte = 8'h00;
    logic        rx_pok = 1'b1;
    logic        ready = 1'b0;

    logic        m_valid, m_err, m_busy, m_to, m_ovr;
    logic [31:0] m_data;
    logic [3:0]  m_mask;
    logic        l_valid, l_err, l_busy, l_to, l_ovr;
    logic [31:0] l_data;
    logic [3:0]  l_mask;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    uart_frame_collector #(.BYTE_NUM(4), .MSB_FIRST(1'b1), .TIMEOUT_CYCLES(100)) dut_m (
        .clk_i(clk), .rst_n_i(rst_n), .rx_byte_valid_i(rx_valid), .rx_byte_i(rx_byte),
        .rx_parity_ok_i(rx_pok), .frame_ready_i(ready), .frame_valid_o(m_valid),
        .frame_data_o(m_data), .frame_err_o(m_err), .frame_err_mask_o(m_mask),
        .busy_o(m_busy), .timeout_o(m_to), .overrun_o(m_ovr));

    uart_frame_collector #(.BYTE_NUM(4), .MSB_FIRST(1'b0), .TIMEOUT_CYCLES(100)) dut_l (
        .clk_i(clk), .rst_n_i(rst_n), .rx_byte_valid_i(rx_valid), .rx_byte_i(rx_byte),
        .rx_parity_ok_i(rx_pok), .frame_ready_i(ready), .frame_valid_o(l_valid),
        .frame_data_o(l_data), .frame_err_o(l_err), .frame_err_mask_o(l_mask),
        .busy_o(l_busy), .timeout_o(l_to), .overrun_o(l_ovr));

    // Strobe one byte; returns 1 ns after the edge that samples it
    task automatic send(input logic [7:0] b, input logic pok);
        rx_valid = 1'b1;
        rx_byte  = b;
        rx_pok   = pok;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        rx_pok   = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", m_valid); end
        total++; if (m_data !== 32'h0) begin bad++; $display("FAIL reset_data got=%h exp=0", m_data); end
        total++; if ({m_err, m_mask, m_busy, m_to, m_ovr} !== 8'h00) begin bad++;
            $display("FAIL reset_flags got=%b exp=0", {m_err, m_mask, m_busy, m_to, m_ovr}); end
        total++; if ({l_valid, l_data, l_mask} !== 37'h0) begin bad++;
            $display("FAIL reset_lsb got=%h exp=0", {l_valid, l_data, l_mask}); end
        #2 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        ready = 1'b1;
        send(8'h11, 1'b1);
        total++; if (m_busy !== 1'b1) begin bad++; $display("FAIL busy_rise got=%b exp=1", m_busy); end
        send(8'h22, 1'b1);
        send(8'h33, 1'b1);
        total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL early_valid got=%b exp=0", m_valid); end
        send(8'h44, 1'b1);
        total++; if (m_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b exp=1", m_valid); end
        total++; if (m_data !== 32'h11223344) begin bad++; $display("FAIL basic_data got=%h exp=11223344", m_data); end
        total++; if ({m_err, m_mask} !== 5'b0) begin bad++; $display("FAIL basic_err got=%b exp=0", {m_err, m_mask}); end
        total++; if (m_busy !== 1'b0) begin bad++; $display("FAIL busy_fall got=%b exp=0", m_busy); end
        tick();
        total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL basic_accept got=%b exp=0", m_valid); end
    endtask

    task automatic test_parity_lsb();
        ready = 1'b1;
        send(8'h11, 1'b1);
        send(8'h22, 1'b1);
        send(8'h33, 1'b0);
        send(8'h44, 1'b1);
        total++; if (l_data !== 32'h44332211) begin bad++; $display("FAIL lsb_data got=%h exp=44332211", l_data); end
        total++; if (l_mask !== 4'b0100) begin bad++; $display("FAIL lsb_mask got=%b exp=0100", l_mask); end
        total++; if (l_err !== 1'b1) begin bad++; $display("FAIL lsb_err got=%b exp=1", l_err); end
        total++; if (m_data !== 32'h11223344 || m_mask !== 4'b0100) begin bad++;
            $display("FAIL msb_par got=%h/%b exp=11223344/0100", m_data, m_mask); end
        tick();
    endtask

    task automatic test_timeout();
        int early;
        early = 0;
        ready = 1'b1;
        send(8'h55, 1'b1);
        send(8'h66, 1'b1);
        for (int k = 1; k < 100; k++) begin
            tick();
            if (m_to !== 1'b0 || m_busy !== 1'b1) early++;
        end
        total++; if (early !== 0) begin bad++; $display("FAIL to_early got=%0d exp=0", early); end
        tick();
        total++; if (m_to !== 1'b1 || l_to !== 1'b1) begin bad++; $display("FAIL to_pulse got=%b%b exp=11", m_to, l_to); end
        total++; if (m_busy !== 1'b0) begin bad++; $display("FAIL to_busy got=%b exp=0", m_busy); end
        tick();
        total++; if (m_to !== 1'b0) begin bad++; $display("FAIL to_width got=%b exp=0", m_to); end
        send(8'hAA, 1'b1);
        send(8'hBB, 1'b1);
        send(8'hCC, 1'b1);
        send(8'hDD, 1'b1);
        total++; if (m_valid !== 1'b1 || m_data !== 32'hAABBCCDD) begin bad++;
            $display("FAIL to_next got=%b/%h exp=1/aabbccdd", m_valid, m_data); end
        tick();
    endtask

    task automatic test_overrun();
        ready = 1'b0;
        send(8'h01, 1'b1); send(8'h02, 1'b1); send(8'h03, 1'b1); send(8'h04, 1'b1);
        total++; if (m_valid !== 1'b1 || m_data !== 32'h01020304) begin bad++;
            $display("FAIL ovr_a got=%b/%h exp=1/01020304", m_valid, m_data); end
        send(8'h05, 1'b1); send(8'h06, 1'b1); send(8'h07, 1'b1);
        total++; if (m_ovr !== 1'b0) begin bad++; $display("FAIL ovr_early got=%b exp=0", m_ovr); end
        send(8'h08, 1'b0);
        total++; if (m_ovr !== 1'b1) begin bad++; $display("FAIL ovr_pulse got=%b exp=1", m_ovr); end
        total++; if (m_data !== 32'h01020304 || m_err !== 1'b0) begin bad++;
            $display("FAIL ovr_hold got=%h/%b exp=01020304/0", m_data, m_err); end
        tick();
        total++; if (m_ovr !== 1'b0 || m_valid !== 1'b1) begin bad++;
            $display("FAIL ovr_after got=%b/%b exp=0/1", m_ovr, m_valid); end
        ready = 1'b1;
        tick();
        total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL ovr_accept got=%b exp=0", m_valid); end
    endtask

    task automatic test_back_to_back();
        ready = 1'b0;
        send(8'h01, 1'b1); send(8'h02, 1'b1); send(8'h03, 1'b1); send(8'h04, 1'b1);
        send(8'h09, 1'b1); send(8'h0A, 1'b1); send(8'h0B, 1'b1);
        ready = 1'b1;
        send(8'h0C, 1'b1);
        total++; if (m_valid !== 1'b1 || m_data !== 32'h090A0B0C) begin bad++;
            $display("FAIL b2b_load got=%b/%h exp=1/090a0b0c", m_valid, m_data); end
        total++; if (m_ovr !== 1'b0) begin bad++; $display("FAIL b2b_ovr got=%b exp=0", m_ovr); end
        total++; if (l_data !== 32'h0C0B0A09) begin bad++; $display("FAIL b2b_lsb got=%h exp=0c0b0a09", l_data); end
        tick();
        total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL b2b_accept got=%b exp=0", m_valid); end
    endtask

    task automatic test_reset_midframe();
        ready = 1'b0;
        send(8'hF1, 1'b0); send(8'hF2, 1'b1); send(8'hF3, 1'b1); send(8'hF4, 1'b1);
        send(8'hE1, 1'b1); send(8'hE2, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        total++; if ({m_valid, m_data, m_mask, m_err} !== 38'h0) begin bad++;
            $display("FAIL rst_mid_slot got=%h exp=0", {m_valid, m_data, m_mask, m_err}); end
        total++; if ({m_busy, m_to, m_ovr, l_busy, l_valid} !== 5'b0) begin bad++;
            $display("FAIL rst_mid_flags got=%b exp=0", {m_busy, m_to, m_ovr, l_busy, l_valid}); end
        #1 rst_n = 1'b1;
        ready = 1'b1;
        tick();
        send(8'hC1, 1'b1); send(8'hC2, 1'b1); send(8'hC3, 1'b1); send(8'hC4, 1'b1);
        total++; if (m_valid !== 1'b1 || m_data !== 32'hC1C2C3C4 || m_mask !== 4'b0) begin bad++;
            $display("FAIL rst_mid_frame got=%b/%h/%b exp=1/c1c2c3c4/0000", m_valid, m_data, m_mask); end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity_lsb();
        test_timeout();
        test_overrun();
        test_back_to_back();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
